// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative 32-bit multiply/divide unit with HI/LO registers
// Optional macro MULDIV_EARLY_OUT_EN: multiply leaves CALC once the remaining multiplier bits are zero.
module muldiv_unit #(
  parameter int ITER_CNT = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic        sgn,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        mthi,
  input  logic        mtlo,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        op_q, op_d;
  logic        neg_res_q, neg_res_d;
  logic        neg_rem_q, neg_rem_d;
  logic        dz_q, dz_d;
  logic [63:0] acc_q, acc_d;
  logic [63:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        sign_a, sign_b;
  logic [31:0] mag_a, mag_b;
  logic [63:0] acc_mul, acc_div;
  logic [32:0] rem_sh;
  logic [33:0] diff;
  logic        last_iter, early_out;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;

  assign sign_a = sgn & A[31];
  assign sign_b = sgn & B[31];
  assign mag_a  = sign_a ? (~A + 32'd1) : A;
  assign mag_b  = sign_b ? (~B + 32'd1) : B;

  // Multiply step: mplier_q also serves as the divisor register during divide.
  assign acc_mul = acc_q + (mplier_q[0] ? mcand_q : 64'd0);

  // Restoring divide step on acc = {remainder, dividend/quotient}.
  assign rem_sh  = {acc_q[63:32], acc_q[31]};
  assign diff    = {1'b0, rem_sh} - {2'b00, mplier_q};
  assign acc_div = diff[33] ? {rem_sh[31:0], acc_q[30:0], 1'b0}
                            : {diff[31:0],   acc_q[30:0], 1'b1};

  assign last_iter = (cnt_q == 6'(ITER_CNT - 1));
`ifdef MULDIV_EARLY_OUT_EN
  assign early_out = !op_q && (mplier_q[31:1] == 31'd0);
`else
  assign early_out = 1'b0;
`endif

  // Divide-by-zero keeps the all-ones quotient unsigned so lo reads 0xFFFFFFFF.
  assign prod_fix = neg_res_q ? (~acc_q + 64'd1) : acc_q;
  assign quo_fix  = (neg_res_q && !dz_q) ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
  assign rem_fix  = neg_rem_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mthi) hi_d = A;
        if (mtlo) lo_d = A;
        if (start) begin
          state_d   = S_CALC;
          cnt_d     = 6'd0;
          op_d      = op;
          neg_res_d = sign_a ^ sign_b;
          neg_rem_d = sign_a;
          dz_d      = (mag_b == 32'd0);
          acc_d     = op ? {32'd0, mag_a} : 64'd0;
          mcand_d   = {32'd0, mag_a};
          mplier_d  = mag_b;
        end
      end
      S_CALC: begin
        busy  = 1'b1;
        cnt_d = cnt_q + 6'd1;
        if (op_q) begin
          acc_d = acc_div;
        end else begin
          acc_d    = acc_mul;
          mcand_d  = {mcand_q[62:0], 1'b0};
          mplier_d = {1'b0, mplier_q[31:1]};
        end
        if (last_iter || early_out) state_d = S_FIX;
      end
      S_FIX: begin
        busy    = 1'b1;
        state_d = S_DONE;
        if (op_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
        if (mthi) hi_d = A;
        if (mtlo) lo_d = A;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 6'd0;
      op_q      <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      acc_q     <= 64'd0;
      mcand_q   <= 64'd0;
      mplier_q  <= 32'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - randomized self-checking bench for muldiv_unit
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic        sgn = 1'b0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic [31:0] hi, lo;
  logic        busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  muldiv_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .sgn(sgn),
    .A(A), .B(B), .mthi(mthi), .mtlo(mtlo),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference result {hi, lo} from plain arithmetic.
  function automatic logic [63:0] model(input logic o, input logic s, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic signed [31:0] q, rm;
    logic [63:0] r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    if (!o) begin
      if (s) r = sa * sb;
      else   r = {32'd0, a} * {32'd0, b};
    end else if (b == 32'd0) begin
      r = {a, 32'hFFFF_FFFF};
    end else if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        r = {32'd0, 32'h8000_0000};
      end else begin
        q  = $signed(a) / $signed(b);
        rm = $signed(a) % $signed(b);
        r  = {rm, q};
      end
    end else begin
      r = {a % b, a / b};
    end
    return r;
  endfunction

  // Cycles from start-accept to the done cycle.
  function automatic int model_lat(input logic o, input logic s, input logic [31:0] b);
    int calc;
    logic [31:0] m;
    calc = 32;
`ifdef MULDIV_EARLY_OUT_EN
    if (!o) begin
      m = (s && b[31]) ? (~b + 32'd1) : b;
      calc = 1;
      while (calc < 32 && (m >> calc) != 32'd0) calc++;
    end
`endif
    return calc + 2;
  endfunction

  // Issue one operation from IDLE and wait for done (bounded).
  task automatic run_op(input logic o, input logic s, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] h, output logic [31:0] l);
    op = o; sgn = s; A = a; B = b; start = 1'b1;
    tick;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 200) begin
      tick;
      lat++;
    end
    h = hi;
    l = lo;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    tick; tick;
    reset = 1'b1;
    n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi got %h want 0", hi); end
    n_checks++; if (lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo got %h want 0", lo); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
  endtask

  task automatic test_mtlo;
    logic [31:0] h0;
    h0 = hi;
    A = 32'h1234_5678; mtlo = 1'b1;
    tick;
    mtlo = 1'b0;
    n_checks++; if (lo !== 32'h1234_5678) begin n_fail++; $display("FAIL mtlo_lo got %h want 12345678", lo); end
    n_checks++; if (hi !== h0) begin n_fail++; $display("FAIL mtlo_hi got %h want %h", hi, h0); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL mtlo_done got %b want 0", done); end
  endtask

  task automatic test_directed;
    logic [31:0] va [6], vb [6];
    logic        vo [6], vs [6];
    int lat, el;
    logic [31:0] h, l;
    logic [63:0] exp;
    va = '{32'd3, 32'hFFFF_FFFE, 32'hFFFF_FFF9, 32'd10, 32'h8000_0000, 32'hFFFF_FFF9};
    vb = '{32'd5, 32'd3,         32'd2,         32'd0,  32'hFFFF_FFFF, 32'd0};
    vo = '{1'b0,  1'b0,          1'b1,          1'b1,   1'b1,          1'b1};
    vs = '{1'b0,  1'b1,          1'b1,          1'b0,   1'b1,          1'b1};
    for (int i = 0; i < 6; i++) begin
      run_op(vo[i], vs[i], va[i], vb[i], lat, h, l);
      exp = model(vo[i], vs[i], va[i], vb[i]);
      el  = model_lat(vo[i], vs[i], vb[i]);
      n_checks++; if (h !== exp[63:32]) begin n_fail++; $display("FAIL dir%0d_hi got %h want %h", i, h, exp[63:32]); end
      n_checks++; if (l !== exp[31:0]) begin n_fail++; $display("FAIL dir%0d_lo got %h want %h", i, l, exp[31:0]); end
      n_checks++; if (lat != el) begin n_fail++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, el); end
      tick;
    end
  endtask

  task automatic test_random;
    logic o, s;
    logic [31:0] a, b, h, l;
    logic [63:0] exp;
    int lat, el;
    for (int i = 0; i < 24; i++) begin
      o = 1'($urandom_range(0, 1));
      s = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(0, 15));
        2:       b = $urandom;
        default: b = 32'hFFFF_FFFF;
      endcase
      run_op(o, s, a, b, lat, h, l);
      exp = model(o, s, a, b);
      el  = model_lat(o, s, b);
      n_checks++; if (h !== exp[63:32]) begin n_fail++; $display("FAIL rnd%0d_hi op=%b sgn=%b a=%h b=%h got %h want %h", i, o, s, a, b, h, exp[63:32]); end
      n_checks++; if (l !== exp[31:0]) begin n_fail++; $display("FAIL rnd%0d_lo op=%b sgn=%b a=%h b=%h got %h want %h", i, o, s, a, b, l, exp[31:0]); end
      n_checks++; if (lat != el) begin n_fail++; $display("FAIL rnd%0d_latency got %0d want %0d", i, lat, el); end
      tick;
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_done_pulse got %b want 0", i, done); end
    end
  endtask

  task automatic test_busy_ignore;
    logic [63:0] exp;
    int n_done;
    exp = model(1'b0, 1'b0, 32'h0000_1234, 32'hFFFF_FFFF);
    op = 1'b0; sgn = 1'b0; A = 32'h0000_1234; B = 32'hFFFF_FFFF; start = 1'b1;
    tick;
    start = 1'b0;
    n_done = 0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 10) begin
        start = 1'b1; mthi = 1'b1; A = 32'hDEAD_BEEF;
      end
      if (c == 11) begin
        start = 1'b0; mthi = 1'b0;
      end
      n_checks++; if (busy !== (c <= 33)) begin n_fail++; $display("FAIL busy_ignore_busy c%0d got %b want %b", c, busy, (c <= 33)); end
      if (done) begin
        n_done++;
        n_checks++; if (c != 34) begin n_fail++; $display("FAIL busy_ignore_done_cycle got %0d want 34", c); end
      end
      tick;
    end
    n_checks++; if (n_done != 1) begin n_fail++; $display("FAIL busy_ignore_done_count got %0d want 1", n_done); end
    n_checks++; if ({hi, lo} !== exp) begin n_fail++; $display("FAIL busy_ignore_result got %h want %h", {hi, lo}, exp); end
  endtask

  task automatic test_start_with_mthi;
    logic [63:0] exp;
    int lat;
    exp = model(1'b0, 1'b1, 32'hCAFE_F00D, 32'h0000_0007);
    op = 1'b0; sgn = 1'b1; A = 32'hCAFE_F00D; B = 32'h0000_0007; start = 1'b1; mthi = 1'b1;
    tick;
    start = 1'b0; mthi = 1'b0;
    n_checks++; if (hi !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL start_mthi_hi got %h want cafef00d", hi); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL start_mthi_busy got %b want 1", busy); end
    lat = 1;
    while (!done && lat < 200) begin tick; lat++; end
    n_checks++; if ({hi, lo} !== exp) begin n_fail++; $display("FAIL start_mthi_result got %h want %h", {hi, lo}, exp); end
    tick;
  endtask

  task automatic test_done_window;
    int lat;
    logic [31:0] h, l;
    run_op(1'b1, 1'b0, 32'd100, 32'd7, lat, h, l);
    A = 32'h5555_AAAA; mthi = 1'b1; start = 1'b1;
    tick;
    mthi = 1'b0; start = 1'b0;
    n_checks++; if (hi !== 32'h5555_AAAA) begin n_fail++; $display("FAIL done_mthi_hi got %h want 5555aaaa", hi); end
    n_checks++; if (lo !== 32'd14) begin n_fail++; $display("FAIL done_mthi_lo got %h want 0000000e", lo); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL done_start_ignored_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_start_ignored_done got %b want 0", done); end
  endtask

  task automatic test_reset_mid;
    int n_done;
    op = 1'b1; sgn = 1'b0; A = 32'hF00D_0001; B = 32'd3; start = 1'b1; mthi = 1'b1;
    tick;
    start = 1'b0; mthi = 1'b0;
    n_checks++; if (hi !== 32'hF00D_0001) begin n_fail++; $display("FAIL reset_mid_pre_hi got %h want f00d0001", hi); end
    for (int c = 1; c < 20; c++) tick;
    reset = 1'b0;
    tick;
    reset = 1'b1;
    n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL reset_mid_hi got %h want 0", hi); end
    n_checks++; if (lo !== 32'd0) begin n_fail++; $display("FAIL reset_mid_lo got %h want 0", lo); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_mid_busy got %b want 0", busy); end
    n_done = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) n_done++;
      tick;
    end
    n_checks++; if (n_done != 0) begin n_fail++; $display("FAIL reset_mid_done_count got %0d want 0", n_done); end
    n_checks++; if ({hi, lo} !== 64'd0) begin n_fail++; $display("FAIL reset_mid_hold got %h want 0", {hi, lo}); end
  endtask

  initial begin
    #1;
    test_reset;
    test_mtlo;
    test_directed;
    test_random;
    test_busy_ignore;
    test_start_with_mthi;
    test_done_window;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
